// File: rtl/rtc_map_pkg.sv
// RTC register map, FSM states and editor targets
// shared by the edit-path controller.
package rtc_map_pkg;

  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MON   = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_T_HR  = 8'h43;
  localparam logic [7:0] ADDR_T_MIN = 8'h42;
  localparam logic [7:0] ADDR_T_SEC = 8'h41;

  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic [2:0] {
    ST_READ,
    ST_IDLE,
    ST_SEL,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] TGT_HORA  = 2'd0;
  localparam logic [1:0] TGT_FECHA = 2'd1;
  localparam logic [1:0] TGT_TIMER = 2'd2;

  function automatic logic [7:0] reg_addr(
    input logic [3:0] idx
  );
    logic [7:0] a;
    case (idx)
      4'd0:    a = ADDR_HOUR;
      4'd1:    a = ADDR_MIN;
      4'd2:    a = ADDR_SEC;
      4'd3:    a = ADDR_DAY;
      4'd4:    a = ADDR_MON;
      4'd5:    a = ADDR_YEAR;
      4'd6:    a = ADDR_T_HR;
      4'd7:    a = ADDR_T_MIN;
      4'd8:    a = ADDR_T_SEC;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] grp_base(
    input logic [1:0] tgt
  );
    logic [3:0] b;
    case (tgt)
      TGT_FECHA: b = 4'd3;
      TGT_TIMER: b = 4'd6;
      default:   b = 4'd0;
    endcase
    return b;
  endfunction

  // sub 0/1/2 selects the high/mid/low byte
  function automatic logic [7:0] grp_byte(
    input logic [23:0] w,
    input logic [3:0]  sub
  );
    logic [7:0] b;
    case (sub)
      4'd0:    b = w[23:16];
      4'd1:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse from a debounced level input;
// the history bit updates every cycle.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Edit-path sequencer: periodic RTC snapshot,
// button-driven editor selection and group commit.
module rtc_edit_ctrl #(
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BTmode,
  input  logic        BTsel,
  input  logic        BTok,
  input  logic [23:0] time_ed,
  input  logic [23:0] date_ed,
  input  logic [23:0] timer_ed,
  output logic        EN_hora,
  output logic        EN_fecha,
  output logic        EN_timer,
  output logic [71:0] snap,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        busy
);

  import rtc_map_pkg::*;

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_TOP =
    CW'(REFRESH_CYCLES - 1);

  logic mode_e, sel_e, ok_e;

  btn_edge u_mode (
    .clk(clk), .reset(reset),
    .btn(BTmode), .rise(mode_e)
  );
  btn_edge u_sel (
    .clk(clk), .reset(reset),
    .btn(BTsel), .rise(sel_e)
  );
  btn_edge u_ok (
    .clk(clk), .reset(reset),
    .btn(BTok), .rise(ok_e)
  );

  state_t          state_q, state_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [3:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic [23:0]     word_q;
  logic [2:0]      en_d;
  logic            busy_d;
  logic            xfer, rd_last, wr_last;
  logic            req_go;
  logic [23:0]     ed_sel;

  assign xfer    = bus_req & bus_ack;
  assign rd_last = idx_q == LAST_IDX;
  assign wr_last = idx_q == grp_base(tgt_q) + 4'd2;

  always_comb begin
    ed_sel = time_ed;
    case (tgt_q)
      TGT_FECHA: ed_sel = date_ed;
      TGT_TIMER: ed_sel = timer_ed;
      default:   ed_sel = time_ed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_READ;
      tgt_q   <= TGT_HORA;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      ST_READ:
        if (xfer && rd_last) state_d = ST_IDLE;
      ST_IDLE:
        if (mode_e) begin
          state_d = ST_SEL;
          tgt_d   = TGT_HORA;
        end else if (cnt_q == CNT_TOP) begin
          state_d = ST_READ;
        end
      ST_SEL:
        if (ok_e)        state_d = ST_EDIT;
        else if (mode_e) state_d = ST_IDLE;
        else if (sel_e)
          tgt_d = (tgt_q == TGT_TIMER) ?
                  TGT_HORA : tgt_q + 2'd1;
      ST_EDIT:
        if (ok_e)        state_d = ST_COMMIT;
        else if (mode_e) state_d = ST_IDLE;
      ST_COMMIT:
        if (xfer && wr_last) state_d = ST_READ;
      default: state_d = ST_READ;
    endcase
  end

  // enables and busy follow the next state so they stay registered
  always_comb begin
    en_d   = 3'b000;
    busy_d = (state_d == ST_READ) ||
             (state_d == ST_COMMIT);
    if (state_d == ST_EDIT) begin
      unique case (1'b1)
        tgt_d == TGT_FECHA: en_d = 3'b010;
        tgt_d == TGT_TIMER: en_d = 3'b001;
        default:            en_d = 3'b100;
      endcase
    end
  end

  // a refresh from IDLE raises req on the transition edge
  assign req_go = !bus_req &&
    ((state_q == ST_READ) ||
     (state_q == ST_COMMIT) ||
     (state_q == ST_IDLE && state_d == ST_READ));

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 8'h00;
      bus_wdata <= 8'h00;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      word_q    <= 24'h0;
      snap      <= 72'h0;
      EN_hora   <= 1'b0;
      EN_fecha  <= 1'b0;
      EN_timer  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      EN_hora  <= en_d[2];
      EN_fecha <= en_d[1];
      EN_timer <= en_d[0];
      busy     <= busy_d;

      if (xfer) begin
        bus_req <= 1'b0;
      end else if (req_go) begin
        bus_req   <= 1'b1;
        bus_we    <= state_q == ST_COMMIT;
        bus_addr  <= reg_addr(idx_q);
        bus_wdata <= (state_q == ST_COMMIT) ?
          grp_byte(word_q, idx_q - grp_base(tgt_q)) :
          8'h00;
      end

      if (xfer && state_q == ST_READ) begin
        for (int i = 0; i < 9; i++)
          if (idx_q == 4'(i))
            snap[(8-i)*8 +: 8] <= bus_rdata;
        idx_q <= rd_last ? 4'd0 : idx_q + 4'd1;
      end else if (xfer && state_q == ST_COMMIT) begin
        idx_q <= wr_last ? 4'd0 : idx_q + 4'd1;
      end else if (state_q == ST_EDIT &&
                   state_d == ST_COMMIT) begin
        idx_q  <= grp_base(tgt_q);
        word_q <= ed_sel;
      end

      if (state_q == ST_READ && state_d == ST_IDLE)
        cnt_q <= '0;
      else if (state_q == ST_IDLE)
        cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Directed bench for rtc_edit_ctrl with an
// auto-acking RTC bus model and a transfer log.
module tb_rtc_edit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        BTmode = 1'b0, BTsel = 1'b0, BTok = 1'b0;
  logic [23:0] time_ed, date_ed, timer_ed;
  logic        EN_hora, EN_fecha, EN_timer;
  logic [71:0] snap;
  logic        bus_req, bus_we, bus_ack;
  logic [7:0]  bus_addr, bus_wdata, bus_rdata;
  logic        busy;

  always #5 clk = ~clk;

  rtc_edit_ctrl #(.REFRESH_CYCLES(20)) dut (
    .clk(clk), .reset(reset),
    .BTmode(BTmode), .BTsel(BTsel), .BTok(BTok),
    .time_ed(time_ed), .date_ed(date_ed),
    .timer_ed(timer_ed),
    .EN_hora(EN_hora), .EN_fecha(EN_fecha),
    .EN_timer(EN_timer), .snap(snap),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic       stable;
    logic       dropped;
  } xfer_t;

  typedef struct {
    logic       mode;
    logic       sel;
    logic       ok;
    logic [2:0] en;
    logic       busy;
  } row_t;

  xfer_t      log_q[$];
  row_t       rows[12];
  logic [7:0] exp_addr[9];
  logic       resp_en = 1'b1;
  int         lat = 2;
  logic [7:0] rd_base = 8'h10;

  task automatic chk(input string name,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] idx_of(
    input logic [7:0] a
  );
    logic [7:0] r = 8'h0;
    for (int i = 0; i < 9; i++)
      if (exp_addr[i] == a) r = 8'(i);
    return r;
  endfunction

  function automatic logic [71:0] exp_snap(
    input logic [7:0] base
  );
    logic [71:0] s = 72'h0;
    for (int i = 0; i < 9; i++)
      s[(8-i)*8 +: 8] = base + 8'(i);
    return s;
  endfunction

  // bus model: ack after `lat` extra cycles, log each transfer
  initial begin : responder
    xfer_t      cur;
    int         wcnt;
    logic [7:0] a0, d0;
    logic       w0;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
        cur.dropped = !bus_req;
        log_q.push_back(cur);
      end else if (reset || !resp_en || !bus_req) begin
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          a0 = bus_addr;
          w0 = bus_we;
          d0 = bus_wdata;
        end
        if (wcnt >= lat) begin
          bus_ack = 1'b1;
          bus_rdata = rd_base + idx_of(bus_addr);
          cur.addr = bus_addr;
          cur.we = bus_we;
          cur.wdata = bus_wdata;
          cur.stable = (a0 == bus_addr) &&
                       (w0 == bus_we) &&
                       (d0 == bus_wdata);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic wait_busy(input logic v,
                           input string name);
    int n = 0;
    while (busy !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, v);
  endtask

  task automatic check_reads(input string name,
                             input logic [7:0] base,
                             input int first);
    chk({name, "_cnt"}, log_q.size(), first + 9);
    for (int i = 0; i < 9; i++)
      if (first + i < log_q.size())
        chk($sformatf("%s_%0d", name, i),
            {log_q[first+i].we, log_q[first+i].addr,
             log_q[first+i].stable,
             log_q[first+i].dropped},
            {1'b0, exp_addr[i], 1'b1, 1'b1});
    chk({name, "_snap"}, snap, exp_snap(base));
    log_q.delete();
  endtask

  task automatic apply_row(input int r);
    BTmode = rows[r].mode;
    BTsel = rows[r].sel;
    BTok = rows[r].ok;
    @(negedge clk);
    chk($sformatf("row%0d_en", r),
        {EN_hora, EN_fecha, EN_timer}, rows[r].en);
    chk($sformatf("row%0d_busy", r), busy, rows[r].busy);
    BTmode = 1'b0;
    BTsel = 1'b0;
    BTok = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: no finish by 300us");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] wa[3];
    logic [7:0] wd[3];
    int n;

    exp_addr = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25,
                 8'h26, 8'h43, 8'h42, 8'h41};
    wa = '{8'h43, 8'h42, 8'h41};
    wd = '{8'h01, 8'h23, 8'h45};
    rows[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
    rows[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    rows[2]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    rows[3]  = '{1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
    rows[4]  = '{1'b0, 1'b0, 1'b1, 3'b000, 1'b1};
    rows[5]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
    rows[6]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    rows[7]  = '{1'b0, 1'b0, 1'b1, 3'b010, 1'b0};
    rows[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
    rows[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
    rows[10] = '{1'b0, 1'b0, 1'b1, 3'b100, 1'b0};
    rows[11] = '{1'b0, 1'b0, 1'b1, 3'b000, 1'b1};
    time_ed  = 24'h123456;
    date_ed  = 24'h150724;
    timer_ed = 24'h012345;

    repeat (3) @(negedge clk);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_snap", snap, 72'h0);
    chk("rst_en", {EN_hora, EN_fecha, EN_timer}, 3'b000);
    chk("rst_bus", {bus_we, bus_addr, bus_wdata}, 17'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_req", {bus_req, bus_we, bus_addr},
        {1'b1, 1'b0, 8'h23});

    // initial read, then exact refresh spacing
    wait_busy(1'b0, "read1_done");
    chk("read1_en", {EN_hora, EN_fecha, EN_timer}, 3'b000);
    n = 1;
    while (!bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("refresh_gap", n, 21);
    check_reads("read1", 8'h10, 0);

    // mode edge during READ must be ignored
    rd_base = 8'h30;
    BTmode = 1'b1;
    wait_busy(1'b0, "read2_done");
    BTmode = 1'b0;
    BTok = 1'b1;
    @(negedge clk);
    BTok = 1'b0;
    @(negedge clk);
    chk("ok_idle_en", {EN_hora, EN_fecha, EN_timer}, 3'b000);
    check_reads("read2", 8'h30, 0);

    // select timer editor and commit
    for (int r = 0; r < 5; r++) apply_row(r);
    wait_busy(1'b0, "commit_done");
    @(negedge clk);
    chk("commit_cnt", log_q.size(), 12);
    for (int i = 0; i < 3; i++)
      if (i < log_q.size())
        chk($sformatf("wr_%0d", i),
            {log_q[i].we, log_q[i].addr, log_q[i].wdata,
             log_q[i].stable, log_q[i].dropped},
            {1'b1, wa[i], wd[i], 1'b1, 1'b1});
    check_reads("read_after_wr", 8'h30, 3);

    // date edit aborted by a held mode button
    for (int r = 5; r < 8; r++) apply_row(r);
    BTmode = 1'b1;
    @(negedge clk);
    chk("abort_en", {EN_hora, EN_fecha, EN_timer}, 3'b000);
    chk("abort_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    BTmode = 1'b0;
    BTsel = 1'b1;
    @(negedge clk);
    BTsel = 1'b0;
    @(negedge clk);
    BTok = 1'b1;
    @(negedge clk);
    BTok = 1'b0;
    @(negedge clk);
    chk("hold_once_en", {EN_hora, EN_fecha, EN_timer}, 3'b000);
    chk("abort_no_write", log_q.size(), 0);

    wait_busy(1'b1, "read3_start");
    wait_busy(1'b0, "read3_done");
    @(negedge clk);
    check_reads("read3", 8'h30, 0);

    // reset while a commit write waits for ack
    for (int r = 9; r < 11; r++) apply_row(r);
    resp_en = 1'b0;
    apply_row(11);
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wr", {bus_req, bus_we, bus_addr, bus_wdata},
        {1'b1, 1'b1, 8'h23, 8'h12});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", bus_req, 1'b0);
    chk("midrst_snap", snap, 72'h0);
    chk("midrst_busy", busy, 1'b1);
    reset = 1'b0;
    resp_en = 1'b1;
    lat = 1;
    rd_base = 8'h10;
    @(negedge clk);
    chk("restart_req", {bus_req, bus_we, bus_addr},
        {1'b1, 1'b0, 8'h23});
    wait_busy(1'b0, "read4_done");
    @(negedge clk);
    check_reads("read4", 8'h10, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
